// File: rtl/exe_pkg.sv
// Shared types and helpers for the integer execute request path.
// Widths here are the defaults the execute blocks are built with.
package exe_pkg;

  localparam int MASK_W_DEF = 20;
  localparam int DATA_W_DEF = 65;
  localparam int UOP_W_DEF  = 160;

  typedef struct packed {
    logic                  live;
    logic [MASK_W_DEF-1:0] br_mask;
    logic [UOP_W_DEF-1:0]  uop;
    logic [DATA_W_DEF-1:0] rs1;
    logic [DATA_W_DEF-1:0] rs2;
  } exe_entry_t;

  function automatic logic mask_killed(input logic [MASK_W_DEF-1:0] mask,
                                       input logic [MASK_W_DEF-1:0] mispredict);
    return |(mask & mispredict);
  endfunction

endpackage

// File: rtl/exe_req_entry_ram.sv
// Payload storage for the request buffer: one write port, async head read.
// Holds only the immutable part of an entry; live/mask state is kept by the owner.
module exe_req_entry_ram #(
  parameter int DEPTH = 2,
  parameter int W     = 8
) (
  input  logic                     clock,
  input  logic                     we,
  input  logic [$clog2(DEPTH)-1:0] waddr,
  input  logic [W-1:0]             wdata,
  input  logic [$clog2(DEPTH)-1:0] raddr,
  output logic [W-1:0]             rdata
);

  logic [W-1:0] mem [DEPTH];

  always_ff @(posedge clock) begin
    if (we) mem[waddr] <= wdata;
  end

  assign rdata = mem[raddr];

endmodule

// File: rtl/exe_req_skid_buffer.sv
// Register-read -> ALU request buffer with branch-mask tracking and kill/flush.
// Define EXE_REQ_SKID_BYPASS_EN for a 0-cycle path when the buffer is empty.
module exe_req_skid_buffer
  import exe_pkg::*;
#(
  parameter int DEPTH  = 2,
  parameter int MASK_W = exe_pkg::MASK_W_DEF,
  parameter int DATA_W = exe_pkg::DATA_W_DEF,
  parameter int UOP_W  = exe_pkg::UOP_W_DEF
) (
  input  logic                       clock,
  input  logic                       reset,
  input  logic                       io_in_valid,
  output logic                       io_in_ready,
  input  logic [MASK_W-1:0]          io_in_br_mask,
  input  logic [UOP_W-1:0]           io_in_uop,
  input  logic [DATA_W-1:0]          io_in_rs1_data,
  input  logic [DATA_W-1:0]          io_in_rs2_data,
  output logic                       io_out_valid,
  input  logic                       io_out_ready,
  output logic [MASK_W-1:0]          io_out_br_mask,
  output logic [UOP_W-1:0]           io_out_uop,
  output logic [DATA_W-1:0]          io_out_rs1_data,
  output logic [DATA_W-1:0]          io_out_rs2_data,
  input  logic [MASK_W-1:0]          io_brupdate_b1_resolve_mask,
  input  logic [MASK_W-1:0]          io_brupdate_b1_mispredict_mask,
  input  logic                       io_flush,
  output logic [$clog2(DEPTH):0]     io_count,
  output logic [15:0]                io_kill_count
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;
  localparam int PAY_W = UOP_W + 2 * DATA_W;

  logic [PW-1:0]                  head, tail;
  logic [CW-1:0]                  count, count_d;
  logic [DEPTH-1:0]               live;
  logic [DEPTH-1:0][MASK_W-1:0]   mask;
  logic                           in_ready_q;
  logic [15:0]                    kill_cnt;

  logic nonempty, head_kill, head_ok, in_kill, push, pop, discard, byp;
  logic [PAY_W-1:0] rd_pay;

  assign nonempty  = (count != '0);
  assign head_kill = io_flush | mask_killed(mask[head], io_brupdate_b1_mispredict_mask);
  assign head_ok   = live[head] & ~head_kill;
  assign discard   = nonempty & ~head_ok;
  assign in_kill   = io_flush | mask_killed(io_in_br_mask, io_brupdate_b1_mispredict_mask);

`ifdef EXE_REQ_SKID_BYPASS_EN
  assign byp  = ~nonempty & io_in_valid & io_out_ready & in_ready_q & ~in_kill;
`else
  assign byp  = 1'b0;
`endif

  // Killed requests still take a slot; the head logic drops them silently later.
  assign push    = io_in_valid & in_ready_q & ~io_flush & ~byp;
  assign pop     = nonempty & (io_out_ready | ~head_ok);
  assign count_d = io_flush ? '0 : count + CW'(push) - CW'(pop);

  exe_req_entry_ram #(.DEPTH(DEPTH), .W(PAY_W)) u_ram (
    .clock (clock),
    .we    (push),
    .waddr (tail),
    .wdata ({io_in_uop, io_in_rs1_data, io_in_rs2_data}),
    .raddr (head),
    .rdata (rd_pay)
  );

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      head       <= '0;
      tail       <= '0;
      count      <= '0;
      live       <= '0;
      mask       <= '0;
      in_ready_q <= 1'b0;
      kill_cnt   <= '0;
    end else begin
      count      <= count_d;
      in_ready_q <= (count_d != CW'(DEPTH));
      if (discard && kill_cnt != 16'hffff) kill_cnt <= kill_cnt + 16'd1;
      if (io_flush) begin
        head <= '0;
        tail <= '0;
        live <= '0;
      end else begin
        head <= head + PW'(pop);
        tail <= tail + PW'(push);
      end
      for (int i = 0; i < DEPTH; i++) begin
        if (push && tail == PW'(i)) begin
          live[i] <= ~in_kill;
          mask[i] <= io_in_br_mask & ~io_brupdate_b1_resolve_mask;
        end else begin
          if (io_flush || mask_killed(mask[i], io_brupdate_b1_mispredict_mask))
            live[i] <= 1'b0;
          mask[i] <= mask[i] & ~io_brupdate_b1_resolve_mask;
        end
      end
    end
  end

  assign io_in_ready   = in_ready_q;
  assign io_count      = count;
  assign io_kill_count = kill_cnt;
  assign io_out_valid  = (nonempty & head_ok) | byp;

  always_comb begin
    io_out_br_mask  = mask[head] & ~io_brupdate_b1_resolve_mask;
    io_out_uop      = rd_pay[PAY_W-1 -: UOP_W];
    io_out_rs1_data = rd_pay[2*DATA_W-1 -: DATA_W];
    io_out_rs2_data = rd_pay[DATA_W-1:0];
    if (byp) begin
      io_out_br_mask  = io_in_br_mask & ~io_brupdate_b1_resolve_mask;
      io_out_uop      = io_in_uop;
      io_out_rs1_data = io_in_rs1_data;
      io_out_rs2_data = io_in_rs2_data;
    end
  end

endmodule

// File: tb/tb_exe_req_skid_buffer.sv
// Directed + random bench for exe_req_skid_buffer against a queue-based model.
module tb_exe_req_skid_buffer;

  localparam int DEPTH = 2;

  logic         clock = 1'b0;
  logic         reset = 1'b1;
  logic         io_in_valid = 1'b0;
  logic         io_in_ready;
  logic [19:0]  io_in_br_mask = '0;
  logic [159:0] io_in_uop = '0;
  logic [64:0]  io_in_rs1_data = '0, io_in_rs2_data = '0;
  logic         io_out_valid;
  logic         io_out_ready = 1'b0;
  logic [19:0]  io_out_br_mask;
  logic [159:0] io_out_uop;
  logic [64:0]  io_out_rs1_data, io_out_rs2_data;
  logic [19:0]  io_brupdate_b1_resolve_mask = '0;
  logic [19:0]  io_brupdate_b1_mispredict_mask = '0;
  logic         io_flush = 1'b0;
  logic [1:0]   io_count;
  logic [15:0]  io_kill_count;

  exe_req_skid_buffer #(.DEPTH(DEPTH)) dut (
    .clock(clock), .reset(reset),
    .io_in_valid(io_in_valid), .io_in_ready(io_in_ready),
    .io_in_br_mask(io_in_br_mask), .io_in_uop(io_in_uop),
    .io_in_rs1_data(io_in_rs1_data), .io_in_rs2_data(io_in_rs2_data),
    .io_out_valid(io_out_valid), .io_out_ready(io_out_ready),
    .io_out_br_mask(io_out_br_mask), .io_out_uop(io_out_uop),
    .io_out_rs1_data(io_out_rs1_data), .io_out_rs2_data(io_out_rs2_data),
    .io_brupdate_b1_resolve_mask(io_brupdate_b1_resolve_mask),
    .io_brupdate_b1_mispredict_mask(io_brupdate_b1_mispredict_mask),
    .io_flush(io_flush), .io_count(io_count), .io_kill_count(io_kill_count)
  );

  always #5 clock = ~clock;

  typedef struct {
    bit           live;
    logic [19:0]  mask;
    logic [159:0] uop;
    logic [64:0]  rs1;
    logic [64:0]  rs2;
  } ment_t;

  ment_t       q[$];
  bit          m_ready = 0;
  int unsigned m_kc = 0;
  int          n_cmp = 0;
  int          n_bad = 0;

  task automatic chk(input string tag, input logic [255:0] obs, input logic [255:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: got %0h want %0h", tag, obs, exp);
    end
  endtask

  task automatic new_payload();
    io_in_uop      = {$urandom, $urandom, $urandom, $urandom, $urandom};
    io_in_rs1_data = {1'($urandom), $urandom, $urandom};
    io_in_rs2_data = {1'($urandom), $urandom, $urandom};
  endtask

  task automatic drive(input bit v, input logic [19:0] m, input bit ord,
                       input logic [19:0] res, input logic [19:0] mis, input bit fl);
    io_in_valid = v; io_in_br_mask = m; io_out_ready = ord;
    io_brupdate_b1_resolve_mask = res; io_brupdate_b1_mispredict_mask = mis;
    io_flush = fl;
  endtask

  // Called at a falling edge with inputs applied; checks, then advances one clock.
  task automatic cycle();
    int sz;
    bit hv, push, pop;
    ment_t e;
    #1;
    sz = q.size();
    hv = 0;
    if (sz > 0)
      hv = q[0].live && !io_flush && ((q[0].mask & io_brupdate_b1_mispredict_mask) == 0);
    push = io_in_valid && m_ready && !io_flush;
    pop  = (sz > 0) && (io_out_ready || !hv);
    chk("count", 256'(io_count), 256'(sz));
    chk("in_ready", 256'(io_in_ready), 256'(m_ready));
    chk("kill_count", 256'(io_kill_count), 256'(m_kc));
    chk("out_valid", 256'(io_out_valid), 256'(hv));
    if (hv) begin
      chk("out_mask", 256'(io_out_br_mask), 256'(q[0].mask & ~io_brupdate_b1_resolve_mask));
      chk("out_uop", 256'(io_out_uop), 256'(q[0].uop));
      chk("out_rs1", 256'(io_out_rs1_data), 256'(q[0].rs1));
      chk("out_rs2", 256'(io_out_rs2_data), 256'(q[0].rs2));
    end
    @(posedge clock);
    if (sz > 0 && !hv && m_kc < 65535) m_kc++;
    if (io_flush) q.delete();
    else begin
      if (pop) void'(q.pop_front());
      foreach (q[i]) begin
        if ((q[i].mask & io_brupdate_b1_mispredict_mask) != 0) q[i].live = 0;
        q[i].mask = q[i].mask & ~io_brupdate_b1_resolve_mask;
      end
      if (push) begin
        e.live = ((io_in_br_mask & io_brupdate_b1_mispredict_mask) == 0);
        e.mask = io_in_br_mask & ~io_brupdate_b1_resolve_mask;
        e.uop = io_in_uop; e.rs1 = io_in_rs1_data; e.rs2 = io_in_rs2_data;
        q.push_back(e);
      end
    end
    m_ready = (q.size() < DEPTH);
    @(negedge clock);
    if (push) new_payload();
  endtask

  task automatic cycles(input int n);
    for (int i = 0; i < n; i++) cycle();
  endtask

  function automatic logic [19:0] rbit(input int pct);
    logic [19:0] one = 20'h1;
    if ($urandom_range(0, 99) < pct) return one << $urandom_range(0, 3);
    return '0;
  endfunction

  initial begin
    new_payload();
    #3;
    chk("rst_count", 256'(io_count), 256'(0));
    chk("rst_in_ready", 256'(io_in_ready), 256'(0));
    chk("rst_out_valid", 256'(io_out_valid), 256'(0));
    chk("rst_kill_count", 256'(io_kill_count), 256'(0));
    @(negedge clock);
    reset = 1'b0;

    // stream: one-cycle latency, ready stays high
    drive(1, '0, 1, '0, '0, 0); cycles(5);
    drive(0, '0, 1, '0, '0, 0); cycles(2);

    // backpressure: third request waits upstream
    drive(1, '0, 0, '0, '0, 0); cycles(3);
    chk("bp_count", 256'(io_count), 256'(2));
    chk("bp_in_ready", 256'(io_in_ready), 256'(0));
    drive(0, '0, 1, '0, '0, 0); cycles(3);

    // resolve on a stored mask
    drive(1, 20'h5, 0, '0, '0, 0); cycle();
    drive(0, '0, 0, 20'h1, '0, 0); cycle();
    drive(0, '0, 0, '0, '0, 0); #1;
    chk("resolve_stored", 256'(io_out_br_mask), 256'(20'h4));
    #1; drive(0, '0, 1, '0, '0, 0); cycles(2);

    // mispredict kills head, next entry follows
    drive(1, 20'h2, 0, '0, '0, 0); cycle();
    drive(1, 20'h0, 0, '0, '0, 0); cycle();
    drive(0, '0, 1, '0, 20'h2, 0); cycle();
    drive(0, '0, 1, '0, '0, 0); #1;
    chk("kill_count_1", 256'(io_kill_count), 256'(1));
    chk("next_valid", 256'(io_out_valid), 256'(1));
    #1; cycles(2);

    // flush while full with a push offered
    drive(1, '0, 0, '0, '0, 0); cycles(3);
    drive(1, '0, 1, '0, '0, 1); cycle();
    drive(0, '0, 1, '0, '0, 0);
    chk("flush_count", 256'(io_count), 256'(0));
    cycles(2);

    // async reset mid-drain
    drive(1, '0, 0, '0, '0, 0); cycles(3);
    drive(0, '0, 1, '0, '0, 0); cycle();
    #2 reset = 1'b1;
    #1;
    chk("arst_out_valid", 256'(io_out_valid), 256'(0));
    chk("arst_count", 256'(io_count), 256'(0));
    chk("arst_in_ready", 256'(io_in_ready), 256'(0));
    q.delete(); m_ready = 0; m_kc = 0;
    @(negedge clock);
    reset = 1'b0;

    // random traffic
    for (int i = 0; i < 400; i++) begin
      drive($urandom_range(0, 99) < 60, rbit(50), $urandom_range(0, 99) < 55,
            ($urandom_range(0, 2) == 0) ? 20'($urandom_range(0, 15)) : 20'h0,
            rbit(12), $urandom_range(0, 39) == 0);
      cycle();
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/exe_req_skid_buffer.md
# exe_req_skid_buffer

Request buffer between the integer register-read stage and the ALU execution unit. It holds up to DEPTH issued micro-ops with operand data, so a downstream stall does not drop requests. While a request waits, the block applies branch-resolution updates to its branch mask and discards it when a mispredicted branch or a pipeline flush kills it. Downstream sees a plain valid/ready stream of live requests only, in issue order.

## Interface
- DEPTH, 2: entry count; power of two, ≥2.
- MASK_W, 20: branch-mask width.
- DATA_W, 65: operand width, carried per rs1/rs2.
- UOP_W, 160: opaque micro-op payload (everything except br_mask), passed through untouched.
- clock  in  1  sole clock; all state on rising edge.
- reset  in  1  asynchronous, active-high.
- io_in_valid  in  1  request offered.
- io_in_ready  out  1  space available.
- io_in_br_mask  in  MASK_W  branch mask of offered request.
- io_in_uop  in  UOP_W  payload.
- io_in_rs1_data, io_in_rs2_data  in  DATA_W  operands.
- io_out_valid  out  1  live head request.
- io_out_ready  in  1  execution unit accepts.
- io_out_br_mask  out  MASK_W  head mask, already cleared by the current resolve_mask.
- io_out_uop, io_out_rs1_data, io_out_rs2_data  out  as inputs.
- io_brupdate_b1_resolve_mask  in  MASK_W  branches resolved this cycle.
- io_brupdate_b1_mispredict_mask  in  MASK_W  branches mispredicted this cycle.
- io_flush  in  1  kill everything (exception/rollback).
- io_count  out  $clog2(DEPTH)+1  occupancy.
- io_kill_count  out  16  saturating count of entries discarded by kill.

## Operation
- Circular FIFO with head/tail pointers. Pointers wrap modulo DEPTH. Each entry has a live bit.
- Entry kill condition, evaluated every cycle: `(br_mask & mispredict_mask) != 0` or `io_flush`.
- Stored masks update every cycle: `br_mask <= br_mask & ~resolve_mask`.
- Push when io_in_valid & io_in_ready:
  - The written mask is `io_in_br_mask & ~resolve_mask`.
  - The entry is written not-live if the incoming request meets the kill condition.
  - A not-live entry still consumes the slot.
- Head handling:
  - io_out_valid = count>0 & head live & head not killed this cycle.
  - Pop when io_out_valid & io_out_ready.
  - Pop also when count>0 and the head is not live or is killed this cycle (silent discard).
  - io_kill_count increments only for the silent discard of a valid head.
- Flush:
  - Clears all live bits and forces io_out_valid=0 that cycle.
  - Resets pointers and count to 0 at the next edge; a push in the same cycle is dropped.
- Occupancy: count' = count + push − pop. Push and pop may coincide at any level below full.

## Timing
- Reset values: count=0, pointers=0, all live bits 0, io_out_valid=0, io_kill_count=0.
- io_in_ready=0 while reset is high.
- io_in_ready = (count < DEPTH), registered. It does not depend on io_out_ready.
- At full, no push occurs even if a pop happens the same cycle.
- Latency, input to output: 1 cycle (without the bypass macro).
- io_out_valid and io_out_br_mask depend combinationally on the brupdate masks and io_flush only.
- No other input-to-output combinational path exists.
- Reset mid-operation discards all entries immediately.

## Configuration
- EXE_REQ_SKID_BYPASS_EN defined:
  - When count==0, io_in_valid=1, io_out_ready=1 and the request is not killed, the request drives the outputs in the same cycle and is not stored.
  - This is a 0-cycle latency path, which adds a combinational path from in to out.
- Not defined: every request is stored first, with 1-cycle minimum latency.

## Structure
- Shared package exe_pkg holds:
  - MASK_W and DATA_W defaults.
  - The entry struct {live, br_mask, uop, rs1, rs2}.
  - The kill-check function mask_killed(mask, mispredict).
- One sub-module, exe_req_entry_ram: DEPTH×entry storage with a write port and an async read of the head. Control stays in the top.

## Test plan
- Stream: 4 pushes with io_out_ready=1, DEPTH=2 -> outputs appear 1 cycle after each push, in order, and io_in_ready stays 1.
- Backpressure: io_out_ready=0, 3 pushes -> count=2, io_in_ready=0 and the third request is held upstream. Releasing ready drains A then B.
- Resolve: stored mask 0x00005, resolve_mask=0x00001 -> io_out_br_mask=0x00004 the same cycle and stored as 0x00004 afterwards.
- Mispredict: head mask 0x00002, next entry mask 0x00000, mispredict_mask=0x00002 -> head discarded without io_out_valid, io_kill_count=1, the next entry is output next cycle.
- Flush while full with a simultaneous push -> io_out_valid=0 that cycle, count=0 next cycle, the pushed request is lost.
- Async reset asserted mid-drain -> io_out_valid=0 and count=0 immediately, before the next clock edge.
